// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter: access types,
// response kinds and the store lane helpers used by the grant path.
package mem_arbiter_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  typedef enum logic [2:0] {
    RESP_NONE   = 3'd0,
    RESP_IF     = 3'd1,
    RESP_LS_LD  = 3'd2,
    RESP_LS_ST  = 3'd3,
    RESP_LS_ERR = 3'd4
  } resp_t;

  // A load/store is legal when its type is defined and the address is
  // naturally aligned for the access size.
  function automatic logic ls_access_ok(input logic       we,
                                        input logic [2:0] ld_type,
                                        input logic [2:0] st_type,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (st_type)
        ST_SB:   ok = 1'b1;
        ST_SH:   ok = ~off[0];
        ST_SW:   ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (ld_type)
        LD_LB, LD_LBU: ok = 1'b1;
        LD_LH, LD_LHU: ok = ~off[0];
        LD_LW:         ok = (off == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] st_type,
                                          input logic [1:0] off);
    logic [3:0] be;
    case (st_type)
      ST_SB:   be = 4'b0001 << off;
      ST_SH:   be = off[1] ? 4'b1100 : 4'b0011;
      ST_SW:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0]  st_type,
                                             input logic [31:0] wdata);
    logic [31:0] d;
    case (st_type)
      ST_SB:   d = {4{wdata[7:0]}};
      ST_SH:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_arbiter_load_align.sv
// Picks the addressed byte/halfword out of a RAM word and sign- or
// zero-extends it according to the load type.
module mem_arbiter_load_align
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = word[7:0];
      2'd1:    byte_lane = word[15:8];
      2'd2:    byte_lane = word[23:16];
      default: byte_lane = word[31:24];
    endcase
    half_lane = offset[1] ? word[31:16] : word[15:0];

    case (load_type)
      LD_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      LD_LBU:  result = {24'b0, byte_lane};
      LD_LH:   result = {{16{half_lane[15]}}, half_lane};
      LD_LHU:  result = {16'b0, half_lane};
      LD_LW:   result = word;
      default: result = 32'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store unit,
// with LSU priority bounded by a starvation streak counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int ADDR_W        = 13,
  parameter  int MAX_LS_STREAK = 4,
  localparam int STREAK_W      = $clog2(MAX_LS_STREAK + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [31:0]         if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [31:0]         ls_addr,
  input  logic [31:0]         ls_wdata,
  input  logic [2:0]          ls_load_type,
  input  logic [2:0]          ls_store_type,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [31:0]         ls_rdata,
  output logic                ls_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [3:0]          mem_be,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output resp_t               dbg_resp,
  output logic [STREAK_W-1:0] dbg_streak
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  // Handshake: a request is accepted in the cycle its gnt is high; the
  // response (rvalid, plus rdata/err) follows exactly one cycle later.
  resp_t               resp_q;
  logic [STREAK_W-1:0] streak_q;
  logic [1:0]          off_q;
  logic [2:0]          type_q;
  logic                if_starved;
  logic                ls_ok;
  logic [31:0]         ls_load_data;
  logic                unused_bits;

  assign if_starved = if_req && (streak_q == STREAK_MAX);
  assign ls_ok      = ls_access_ok(ls_we, ls_load_type, ls_store_type, ls_addr[1:0]);

  always_comb begin
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = ls_addr[ADDR_W+1:2];
    mem_wdata = store_data(ls_store_type, ls_wdata);
    if (reset_n) begin
      if (ls_req && !if_starved) begin
        ls_gnt = 1'b1;
        mem_en = ls_ok;
        mem_we = ls_ok && ls_we;
        if (ls_ok && ls_we) mem_be = store_be(ls_store_type, ls_addr[1:0]);
      end else if (if_req) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = if_addr[ADDR_W+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q   <= RESP_NONE;
      streak_q <= '0;
      off_q    <= 2'b00;
      type_q   <= 3'b000;
    end else begin
      if (ls_gnt) begin
        if (!ls_ok)     resp_q <= RESP_LS_ERR;
        else if (ls_we) resp_q <= RESP_LS_ST;
        else            resp_q <= RESP_LS_LD;
        off_q  <= ls_addr[1:0];
        type_q <= ls_load_type;
      end else if (if_gnt) begin
        resp_q <= RESP_IF;
      end else begin
        resp_q <= RESP_NONE;
      end

      // Streak only measures LSU wins while fetch is actually waiting.
      if (if_gnt || !if_req) streak_q <= '0;
      else if (ls_gnt && streak_q != STREAK_MAX) streak_q <= streak_q + STREAK_W'(1);
    end
  end

  mem_arbiter_load_align u_load_align (
    .word      (mem_rdata),
    .offset    (off_q),
    .load_type (type_q),
    .result    (ls_load_data)
  );

  assign if_rvalid  = (resp_q == RESP_IF) && !flush;
  assign if_rdata   = if_rvalid ? mem_rdata : NOP_INSN;
  assign ls_rvalid  = resp_q inside {RESP_LS_LD, RESP_LS_ST, RESP_LS_ERR};
  assign ls_err     = (resp_q == RESP_LS_ERR);
  assign ls_rdata   = (resp_q == RESP_LS_LD) ? ls_load_data : 32'b0;
  assign dbg_resp   = resp_q;
  assign dbg_streak = streak_q;

  assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], ls_addr[31:ADDR_W+2]};

  a_one_grant: assert property (@(posedge clk) disable iff (!reset_n)
    !(if_gnt && ls_gnt));
  a_en_needs_gnt: assert property (@(posedge clk) disable iff (!reset_n)
    mem_en |-> (if_gnt || ls_gnt));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed corner cases plus a randomized run checked
// against a transaction-level model with its own shadow copy of the RAM.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int ADDR_W = 13;
  localparam int MAX    = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic [2:0]  ls_load_type, ls_store_type;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  resp_t       dbg_resp;
  logic [2:0]  dbg_streak;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram    [0:8191];
  logic [31:0] shadow [0:8191];
  logic [34:0] exp_q[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_LS_STREAK(MAX)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_load_type(ls_load_type), .ls_store_type(ls_store_type),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_resp(dbg_resp), .dbg_streak(dbg_streak)
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // ---------------- reference model helpers ----------------
  function automatic int acc_size(input logic we, input logic [2:0] lt, input logic [2:0] st);
    if (we) return (st == 3'd0) ? 1 : (st == 3'd1) ? 2 : (st == 3'd2) ? 4 : 0;
    return (lt == 3'd0 || lt == 3'd4) ? 1 : (lt == 3'd1 || lt == 3'd5) ? 2 : (lt == 3'd2) ? 4 : 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] lt, input int off);
    int sz;
    logic [31:0] mask, v;
    sz   = acc_size(1'b0, lt, 3'd0);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = (w >> (8 * off)) & mask;
    if ((lt == 3'd0 || lt == 3'd1) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; flush = 1'b0;
    if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
    ls_load_type = 3'd0; ls_store_type = 3'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    for (int i = 0; i < 8192; i++) begin
      logic [31:0] w;
      w = $urandom;
      ram[i] <= w;
      shadow[i] = w;
    end
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; ls_store_type = ST_SW;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (if_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_if_gnt: got %b want 0", if_gnt); end
    n_cmp++; if (ls_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_ls_gnt: got %b want 0", ls_gnt); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_be !== 4'b0) begin n_bad++; $display("FAIL rst_mem_be: got %b want 0000", mem_be); end
    n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_if_rvalid: got %b want 0", if_rvalid); end
    n_cmp++; if (ls_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_ls_rvalid: got %b want 0", ls_rvalid); end
    n_cmp++; if (ls_err !== 1'b0) begin n_bad++; $display("FAIL rst_ls_err: got %b want 0", ls_err); end
    n_cmp++; if (if_rdata !== 32'h0000_0013) begin n_bad++; $display("FAIL rst_if_rdata: got %h want 00000013", if_rdata); end
    n_cmp++; if (ls_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_ls_rdata: got %h want 0", ls_rdata); end
    n_cmp++; if (dbg_resp !== RESP_NONE) begin n_bad++; $display("FAIL rst_resp: got %0d want 0", dbg_resp); end
    n_cmp++; if (dbg_streak !== 3'd0) begin n_bad++; $display("FAIL rst_streak: got %0d want 0", dbg_streak); end
    idle_inputs();
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int cycles);
    logic        if_pend = 1'b0, ls_pend = 1'b0;
    logic [31:0] ia = 0, la = 0, lwd = 0;
    logic        lwe = 1'b0;
    logic [2:0]  lt = 0, st = 0;
    logic [2:0]  ld_tab [5];
    int          streak_m = 0;
    logic [34:0] e;
    int          kind, sz, off, idx;
    logic [31:0] edata, w, exp_wd;
    logic [3:0]  exp_be;
    logic        eg_ls, eg_if, ok, exp_ifv, if_was;
    ld_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    exp_q.delete();
    exp_q.push_back({3'd0, 32'd0});
    for (int c = 0; c < cycles; c++) begin
      if (!if_pend && $urandom_range(0, 3) != 0) begin
        if_pend = 1'b1; ia = 32'($urandom_range(0, 1023));
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend = 1'b1;
        lwe = 1'($urandom_range(0, 1));
        la  = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 1) == 1) la = la & ~32'h3;
        lwd = $urandom;
        lt  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : ld_tab[$urandom_range(0, 4)];
        st  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      end
      if_req = if_pend; if_addr = ia;
      ls_req = ls_pend; ls_we = lwe; ls_addr = la; ls_wdata = lwd;
      ls_load_type = lt; ls_store_type = st;
      flush = ($urandom_range(0, 4) == 0);
      #1;
      // responses owed for last cycle's grant
      e = exp_q.pop_front();
      kind = int'(e[34:32]); edata = e[31:0];
      exp_ifv = (kind == 1) && !flush;
      n_cmp++; if (if_rvalid !== exp_ifv) begin n_bad++; $display("FAIL rnd_if_rvalid c=%0d: got %b want %b", c, if_rvalid, exp_ifv); end
      n_cmp++; if (if_rdata !== (exp_ifv ? edata : 32'h13)) begin n_bad++; $display("FAIL rnd_if_rdata c=%0d: got %h want %h", c, if_rdata, exp_ifv ? edata : 32'h13); end
      n_cmp++; if (ls_rvalid !== (kind >= 2)) begin n_bad++; $display("FAIL rnd_ls_rvalid c=%0d: got %b want %b", c, ls_rvalid, kind >= 2); end
      n_cmp++; if (ls_err !== (kind == 4)) begin n_bad++; $display("FAIL rnd_ls_err c=%0d: got %b want %b", c, ls_err, kind == 4); end
      n_cmp++; if (ls_rdata !== ((kind == 2) ? edata : 32'h0)) begin n_bad++; $display("FAIL rnd_ls_rdata c=%0d: got %h want %h", c, ls_rdata, (kind == 2) ? edata : 32'h0); end
      // grants for this cycle
      eg_ls = ls_pend && !(if_pend && streak_m == MAX);
      eg_if = if_pend && !eg_ls;
      sz  = acc_size(lwe, lt, st);
      off = int'(la % 4);
      ok  = (sz != 0) && ((off % sz) == 0);
      n_cmp++; if (ls_gnt !== eg_ls) begin n_bad++; $display("FAIL rnd_ls_gnt c=%0d: got %b want %b", c, ls_gnt, eg_ls); end
      n_cmp++; if (if_gnt !== eg_if) begin n_bad++; $display("FAIL rnd_if_gnt c=%0d: got %b want %b", c, if_gnt, eg_if); end
      n_cmp++; if (mem_en !== (eg_if || (eg_ls && ok))) begin n_bad++; $display("FAIL rnd_mem_en c=%0d: got %b want %b", c, mem_en, eg_if || (eg_ls && ok)); end
      n_cmp++; if (mem_we !== (eg_ls && ok && lwe)) begin n_bad++; $display("FAIL rnd_mem_we c=%0d: got %b want %b", c, mem_we, eg_ls && ok && lwe); end
      if (eg_if) begin
        n_cmp++; if (mem_addr !== 13'(ia >> 2)) begin n_bad++; $display("FAIL rnd_if_addr c=%0d: got %h want %h", c, mem_addr, 13'(ia >> 2)); end
      end
      if (eg_ls && ok) begin
        n_cmp++; if (mem_addr !== 13'(la >> 2)) begin n_bad++; $display("FAIL rnd_ls_addr c=%0d: got %h want %h", c, mem_addr, 13'(la >> 2)); end
      end
      if (eg_ls && ok && lwe) begin
        exp_be = 4'(((1 << sz) - 1) << off);
        for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = lwd[8*(l % sz) +: 8];
        n_cmp++; if (mem_be !== exp_be) begin n_bad++; $display("FAIL rnd_mem_be c=%0d: got %b want %b", c, mem_be, exp_be); end
        n_cmp++; if (mem_wdata !== exp_wd) begin n_bad++; $display("FAIL rnd_mem_wdata c=%0d: got %h want %h", c, mem_wdata, exp_wd); end
      end
      // advance the model
      if_was = if_pend;
      if (eg_ls) begin
        idx = int'(la >> 2);
        if (!ok) exp_q.push_back({3'd4, 32'd0});
        else if (lwe) begin
          w = shadow[idx];
          for (int k = 0; k < sz; k++) w[8*(off+k) +: 8] = lwd[8*k +: 8];
          shadow[idx] = w;
          exp_q.push_back({3'd3, 32'd0});
        end else exp_q.push_back({3'd2, model_load(shadow[idx], lt, off)});
        ls_pend = 1'b0;
      end else if (eg_if) begin
        exp_q.push_back({3'd1, shadow[int'(ia >> 2)]});
        if_pend = 1'b0;
      end else exp_q.push_back({3'd0, 32'd0});
      if (eg_if || !if_was) streak_m = 0;
      else if (eg_ls && streak_m < MAX) streak_m++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_lb_sign();
    ram[13'h40] <= 32'h80FF_1234;
    shadow[32'h40] = 32'h80FF_1234;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_load_type = LD_LB; ls_addr = 32'h103;
    #1;
    n_cmp++; if (ls_gnt !== 1'b1) begin n_bad++; $display("FAIL lb_gnt: got %b want 1", ls_gnt); end
    n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL lb_mem_en: got %b want 1", mem_en); end
    n_cmp++; if (mem_addr !== 13'h40) begin n_bad++; $display("FAIL lb_mem_addr: got %h want 040", mem_addr); end
    @(posedge clk); #1;
    ls_req = 1'b0;
    n_cmp++; if (ls_rvalid !== 1'b1) begin n_bad++; $display("FAIL lb_rvalid: got %b want 1", ls_rvalid); end
    n_cmp++; if (ls_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", ls_rdata); end
    @(posedge clk); #1;
    n_cmp++; if (ls_rvalid !== 1'b0) begin n_bad++; $display("FAIL lb_rvalid_pulse: got %b want 0", ls_rvalid); end
    idle_inputs();
  endtask

  task automatic test_sh_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_store_type = ST_SH; ls_addr = 32'h202; ls_wdata = 32'h0000_BEEF;
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL sh_mem_we: got %b want 1", mem_we); end
    n_cmp++; if (mem_be !== 4'b1100) begin n_bad++; $display("FAIL sh_mem_be: got %b want 1100", mem_be); end
    n_cmp++; if (mem_wdata !== 32'hBEEF_BEEF) begin n_bad++; $display("FAIL sh_mem_wdata: got %h want beefbeef", mem_wdata); end
    n_cmp++; if (mem_addr !== 13'h80) begin n_bad++; $display("FAIL sh_mem_addr: got %h want 080", mem_addr); end
    @(posedge clk); #1;
    ls_we = 1'b0; ls_load_type = LD_LH;
    n_cmp++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h0 || ls_err !== 1'b0) begin n_bad++; $display("FAIL sh_resp: got v=%b d=%h e=%b want 1/0/0", ls_rvalid, ls_rdata, ls_err); end
    @(posedge clk); #1;
    ls_load_type = LD_LHU;
    n_cmp++; if (ls_rdata !== 32'hFFFF_BEEF) begin n_bad++; $display("FAIL sh_lh_back: got %h want ffffbeef", ls_rdata); end
    @(posedge clk); #1;
    ls_req = 1'b0;
    n_cmp++; if (ls_rdata !== 32'h0000_BEEF) begin n_bad++; $display("FAIL sh_lhu_back: got %h want 0000beef", ls_rdata); end
    shadow[32'h80][31:16] = 16'hBEEF;
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    ls_req = 1'b1; ls_we = 1'b0; ls_load_type = LD_LW; ls_addr = 32'h101;
    #1;
    n_cmp++; if (ls_gnt !== 1'b1) begin n_bad++; $display("FAIL mis_gnt: got %b want 1", ls_gnt); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL mis_mem_en: got %b want 0", mem_en); end
    @(posedge clk); #1;
    ls_req = 1'b0;
    n_cmp++; if (ls_rvalid !== 1'b1) begin n_bad++; $display("FAIL mis_rvalid: got %b want 1", ls_rvalid); end
    n_cmp++; if (ls_err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", ls_err); end
    n_cmp++; if (ls_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h want 0", ls_rdata); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_streak();
    logic want_if;
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_load_type = LD_LW; ls_addr = 32'h30;
    for (int i = 0; i < 10; i++) begin
      #1;
      want_if = ((i % (MAX + 1)) == MAX);
      n_cmp++; if (if_gnt !== want_if || ls_gnt !== !want_if) begin n_bad++; $display("FAIL streak_pattern i=%0d: got if=%b ls=%b want if=%b", i, if_gnt, ls_gnt, want_if); end
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    n_cmp++; if (if_gnt !== 1'b1 || mem_addr !== 13'h4) begin n_bad++; $display("FAIL fl_gnt: got gnt=%b addr=%h want 1/004", if_gnt, mem_addr); end
    @(posedge clk); #1;
    if_req = 1'b0; flush = 1'b1;
    #1;
    n_cmp++; if (if_rvalid !== 1'b0) begin n_bad++; $display("FAIL fl_rvalid: got %b want 0", if_rvalid); end
    n_cmp++; if (if_rdata !== 32'h0000_0013) begin n_bad++; $display("FAIL fl_rdata: got %h want 00000013", if_rdata); end
    flush = 1'b0;
    #1;
    n_cmp++; if (if_rvalid !== 1'b1 || if_rdata !== shadow[4]) begin n_bad++; $display("FAIL fl_unflushed: got v=%b d=%h want 1/%h", if_rvalid, if_rdata, shadow[4]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_we = 1'b0; ls_load_type = LD_LW; ls_addr = 32'h40;
    #1;
    n_cmp++; if (ls_gnt !== 1'b1) begin n_bad++; $display("FAIL rm_gnt: got %b want 1", ls_gnt); end
    @(posedge clk); #1;
    ls_req = 1'b0;
    n_cmp++; if (ls_rvalid !== 1'b1) begin n_bad++; $display("FAIL rm_pending: got %b want 1", ls_rvalid); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (ls_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_in_reset: got %b want 0", ls_rvalid); end
    reset_n = 1'b1;
    #1;
    n_cmp++; if (ls_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_after_release: got %b want 0", ls_rvalid); end
    @(posedge clk); #1;
    n_cmp++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_next_cycle: got ls=%b if=%b want 0/0", ls_rvalid, if_rvalid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_random(1500);
    test_lb_sign();
    test_sh_store();
    test_misaligned();
    test_streak();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
